// File: rtl/topology_loader.sv
// topology_loader: streams topology words into a BRAM, then reads every word back
// and checks it against a shadow copy, reporting sticky error/mismatch status.
module topology_loader #(
  parameter int ADDR_LEN = 2,
  parameter int DATA_LEN = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_LEN:0]   num_words_i,
  input  logic                s_valid_i,
  input  logic [DATA_LEN-1:0] s_data_i,
  output logic                s_ready_o,
  output logic                bram_ena_o,
  output logic                bram_wr_ena_o,
  output logic [ADDR_LEN-1:0] bram_addr_o,
  output logic [DATA_LEN-1:0] bram_data_o,
  input  logic [DATA_LEN-1:0] bram_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                mismatch_o,
  output logic [ADDR_LEN-1:0] mismatch_addr_o
);
  localparam int DEPTH = 2**ADDR_LEN;
  localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_LEN:0] count, counter;
  logic [DATA_LEN-1:0] shadow [DEPTH];
  logic tag1_v, tag2_v;
  logic [ADDR_LEN-1:0] tag1_a, tag2_a;
  logic start_ok, hs, last, bad;
  assign start_ok  = start_i && num_words_i != '0 && num_words_i <= DEPTH_W;
  assign hs        = state == WRITE && s_valid_i;
  assign last      = counter == count - 1'b1;
  assign bad       = tag2_v && bram_data_i != shadow[tag2_a] && !mismatch_o;
  assign s_ready_o = state == WRITE;
  assign busy_o    = state != IDLE;
  assign done_o    = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_ok ? WRITE : start_i ? DONE : IDLE;
      WRITE:   state_nxt = hs && last ? VERIFY : WRITE;
      VERIFY:  state_nxt = last ? DRAIN : VERIFY;
      DRAIN:   state_nxt = tag1_v ? DRAIN : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) state <= reset_i ? IDLE : state_nxt;
  always_ff @(posedge clk_i) if (hs) shadow[counter[ADDR_LEN-1:0]] <= s_data_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count           <= '0;
      counter         <= '0;
      bram_ena_o      <= 1'b0;
      bram_wr_ena_o   <= 1'b0;
      bram_addr_o     <= '0;
      bram_data_o     <= '0;
      tag1_v          <= 1'b0;
      tag2_v          <= 1'b0;
      tag1_a          <= '0;
      tag2_a          <= '0;
      error_o         <= 1'b0;
      mismatch_o      <= 1'b0;
      mismatch_addr_o <= '0;
    end else begin
      bram_ena_o    <= 1'b0;
      bram_wr_ena_o <= 1'b0;
      tag1_v        <= 1'b0;
      tag2_v        <= tag1_v;
      tag2_a        <= tag1_a;
      if (bad) begin
        mismatch_o      <= 1'b1;
        mismatch_addr_o <= tag2_a;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            count           <= num_words_i;
            counter         <= '0;
            error_o         <= 1'b0;
            mismatch_o      <= 1'b0;
            mismatch_addr_o <= '0;
          end else if (start_i) begin
            error_o    <= 1'b1;
            mismatch_o <= 1'b0;
          end
        end
        WRITE: if (hs) begin
          bram_ena_o    <= 1'b1;
          bram_wr_ena_o <= 1'b1;
          bram_addr_o   <= counter[ADDR_LEN-1:0];
          bram_data_o   <= s_data_i;
          counter       <= last ? '0 : counter + 1'b1;
        end
        VERIFY: begin
          bram_ena_o  <= 1'b1;
          bram_addr_o <= counter[ADDR_LEN-1:0];
          tag1_v      <= 1'b1;
          tag1_a      <= counter[ADDR_LEN-1:0];
          counter     <= last ? '0 : counter + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_topology_loader.sv
// tb_topology_loader: scoreboard bench with a BRAM model that can corrupt chosen read addresses.
module tb_topology_loader;
  logic clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, s_valid_i = 1'b0;
  logic [2:0] num_words_i = '0;
  logic [15:0] s_data_i = '0, bram_data_o, bram_data_i = '0;
  logic s_ready_o, bram_ena_o, bram_wr_ena_o, busy_o, done_o, error_o, mismatch_o;
  logic [1:0] bram_addr_o, mismatch_addr_o;
  typedef struct {int cyc; bit err; bit mm; logic [1:0] mma;} done_t;
  logic [17:0] wq[$];
  logic [1:0]  rq[$];
  done_t       dq[$];
  logic [15:0] mem [4];
  logic [3:0]  corrupt = '0;
  int total = 0, bad = 0, cyc = 0;

  topology_loader dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .num_words_i(num_words_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .bram_ena_o(bram_ena_o), .bram_wr_ena_o(bram_wr_ena_o), .bram_addr_o(bram_addr_o),
    .bram_data_o(bram_data_o), .bram_data_i(bram_data_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .mismatch_o(mismatch_o),
    .mismatch_addr_o(mismatch_addr_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Registered-output BRAM; flagged addresses return a flipped MSB on read
  always @(posedge clk_i)
    if (bram_ena_o) begin
      if (bram_wr_ena_o) mem[bram_addr_o] <= bram_data_o;
      else bram_data_i <= mem[bram_addr_o] ^ (corrupt[bram_addr_o] ? 16'h8000 : 16'h0000);
    end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  logic [17:0] me;
  logic [1:0]  mr;
  done_t       md;
  always @(negedge clk_i) begin
    if (bram_ena_o && bram_wr_ena_o) begin
      chk("write_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        me = wq.pop_front();
        chk("write_addr", bram_addr_o, me[17:16]);
        chk("write_data", bram_data_o, me[15:0]);
      end
    end
    if (bram_ena_o && !bram_wr_ena_o) begin
      chk("read_expected", rq.size() != 0, 1);
      if (rq.size() != 0) begin
        mr = rq.pop_front();
        chk("read_addr", bram_addr_o, mr);
      end
    end
    if (done_o) begin
      chk("done_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        md = dq.pop_front();
        chk("done_cycle", cyc, md.cyc);
        chk("done_error", error_o, md.err);
        chk("done_mismatch", mismatch_o, md.mm);
        if (md.mm) chk("done_mismatch_addr", mismatch_addr_o, md.mma);
      end
    end
  end

  task automatic wait_done();
    int g = 0;
    while ((dq.size() + rq.size() + wq.size()) != 0 && g < 60) begin
      @(negedge clk_i);
      g++;
    end
    chk("pending_after_timeout", dq.size() + rq.size() + wq.size(), 0);
    @(negedge clk_i);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic load(input int n, input int mode, input logic [3:0] cmask, input logic [63:0] words);
    logic [15:0] w [4];
    int i = 0, g = 0, fm = -1;
    bit v;
    corrupt = cmask;
    for (int k = 0; k < 4; k++) w[k] = words[16*k +: 16];
    for (int k = 0; k < n; k++) if (cmask[k] && fm < 0) fm = k;
    start_i = 1'b1;
    num_words_i = 3'(n);
    @(negedge clk_i);
    start_i = 1'b0;
    while (i < n && g < 100) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (g % 2 == 0) : 1'($urandom % 2);
      s_valid_i = v;
      s_data_i = v ? w[i] : 16'($urandom);
      if (v && s_ready_o) begin
        wq.push_back({2'(i), w[i]});
        i++;
        if (i == n) begin
          for (int k = 0; k < n; k++) rq.push_back(2'(k));
          dq.push_back('{cyc + n + 3, 1'b0, fm >= 0, fm >= 0 ? 2'(fm) : 2'd0});
        end
      end
      @(negedge clk_i);
      g++;
    end
    s_valid_i = 1'b0;
    chk("words_accepted", i, n);
    wait_done();
  endtask

  task automatic err_req(input int n);
    start_i = 1'b1;
    num_words_i = 3'(n);
    dq.push_back('{cyc + 1, 1'b1, 1'b0, 2'd0});
    @(negedge clk_i);
    start_i = 1'b0;
    chk("err_busy_high", busy_o, 1);
    chk("err_flag", error_o, 1);
    @(negedge clk_i);
    chk("err_busy_one_cycle", busy_o, 0);
    chk("err_done_one_cycle", done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_bram_ena", bram_ena_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_mismatch", mismatch_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    load(3, 0, 4'b0000, 64'h0000_0001_0003_0002);
    load(4, 1, 4'b0000, {$urandom, $urandom});
    load(3, 0, 4'b0110, {$urandom, $urandom});
    repeat (3) @(negedge clk_i);
    chk("mismatch_held", mismatch_o, 1);
    chk("mismatch_addr_held", mismatch_addr_o, 1);
    load(4, 0, 4'b0000, {$urandom, $urandom});
    chk("mismatch_cleared", mismatch_o, 0);
    err_req(0);
    err_req(5);
    err_req(7);
    start_i = 1'b1;
    num_words_i = 3'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 16'h00AA;
    chk("midwrite_ready", s_ready_o, 1);
    wq.push_back({2'd0, 16'h00AA});
    @(negedge clk_i);
    s_valid_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("midwrite_rst_ready", s_ready_o, 0);
    chk("midwrite_rst_busy", busy_o, 0);
    chk("midwrite_rst_error", error_o, 0);
    load(2, 0, 4'b0000, {$urandom, $urandom});
    for (int r = 0; r < 10; r++)
      load($urandom_range(1, 4), 2, 4'($urandom), {$urandom, $urandom});
    chk("queues_empty", wq.size() + rq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/topology_loader.md
TOPOLOGY_LOADER -- requirements
Module: topology_loader

Interface
REQ-001 Parameter ADDR_LEN, default 2, SHALL set the BRAM address width; DEPTH = 2**ADDR_LEN.
REQ-002 Parameter DATA_LEN, default 16, SHALL set the topology word width.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start_i  in  1  SHALL be a load request, sampled only in IDLE.
REQ-006 num_words_i  in  ADDR_LEN+1  SHALL be the word count to load, sampled with start_i.
REQ-007 s_valid_i  in  1  SHALL mark s_data_i valid.
REQ-008 s_data_i  in  DATA_LEN  SHALL be the topology word (layer size).
REQ-009 s_ready_o  out  1  SHALL be high exactly while state is WRITE.
REQ-010 bram_ena_o, bram_wr_ena_o  out  1 each  SHALL be registered BRAM enable and write enable.
REQ-011 bram_addr_o  out  ADDR_LEN; bram_data_o  out  DATA_LEN  SHALL be registered BRAM address and write data.
REQ-012 bram_data_i  in  DATA_LEN  SHALL be BRAM read data, valid the cycle after the BRAM samples a read address (registered BRAM output).
REQ-013 busy_o  out  1  SHALL be high in every state except IDLE.
REQ-014 done_o  out  1  SHALL pulse high for exactly one cycle per completed or rejected request.
REQ-015 error_o, mismatch_o  out  1 each; mismatch_addr_o  out  ADDR_LEN  SHALL be sticky status flags and first-mismatch address.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, VERIFY, DRAIN, DONE.
REQ-017 IDLE: on start_i with 1 <= num_words_i <= DEPTH, latch count, clear error_o/mismatch_o/mismatch_addr_o, clear write counter, go WRITE.
REQ-018 IDLE: on start_i with num_words_i = 0 or > DEPTH, set error_o, clear mismatch_o, go DONE; no BRAM access issued.
REQ-019 WRITE: each cycle with s_valid_i & s_ready_o SHALL register bram_ena_o=1, bram_wr_ena_o=1, bram_addr_o=counter, bram_data_o=s_data_i, store the word in a DEPTH-entry shadow array at counter, increment counter.
REQ-020 WRITE: cycles without handshake SHALL register bram_ena_o=0, bram_wr_ena_o=0; s_valid_i gaps of any length allowed.
REQ-021 The handshake on counter = count-1 SHALL move to VERIFY next cycle; counter reset to 0.
REQ-022 VERIFY: issue one read per cycle (bram_ena_o=1, bram_wr_ena_o=0, bram_addr_o=counter) for addresses 0..count-1, then go DRAIN.
REQ-023 Each read SHALL carry a 2-stage valid/address tag; at tag stage 2 compare bram_data_i with shadow[tag address].
REQ-024 On the first compare mismatch, set mismatch_o and capture mismatch_addr_o; later mismatches SHALL NOT overwrite it.
REQ-025 DRAIN: hold bram_ena_o=0 until tag pipeline empty, then go DONE.
REQ-026 DONE: assert done_o for one cycle, go IDLE.
REQ-027 Latency: if last write handshake occurs in cycle t, done_o SHALL be high in cycle t+count+3.
REQ-028 start_i outside IDLE SHALL be ignored; s_valid_i outside WRITE SHALL be ignored (no write, no data consumed).
REQ-029 Counter SHALL be ADDR_LEN+1 bits; count = DEPTH SHALL address 0..DEPTH-1 without wrap.

Reset
REQ-030 reset_i high at a clock edge SHALL force IDLE, all outputs 0, counters, tag pipeline, and shadow valid state cleared, from any state including mid-WRITE/VERIFY.
REQ-031 After reset release, the next start_i SHALL be accepted normally.

Verification
REQ-032 Reset asserted 2 cycles -> s_ready_o, bram_ena_o, busy_o, done_o, error_o, mismatch_o all 0.
REQ-033 start_i, num_words_i=3, stream 0x0002,0x0003,0x0001 back-to-back -> BRAM writes (0,0x0002),(1,0x0003),(2,0x0001), reads 0,1,2, done_o 1 cycle at t+6, mismatch_o=0, error_o=0.
REQ-034 num_words_i=4 with s_valid_i low every other cycle -> exactly 4 writes, addresses 0..3 in order, no write on idle cycles, done_o at t+7.
REQ-035 BRAM model corrupts read of address 1 and 2 -> mismatch_o=1, mismatch_addr_o=1, held until next accepted start_i.
REQ-036 start_i with num_words_i=0, then with 5 -> error_o=1, done_o pulse next cycle, bram_ena_o stays 0, busy_o high one cycle only.
REQ-037 reset_i asserted after 1 of 3 words written -> IDLE, s_ready_o=0; new start_i, num_words_i=2 completes with mismatch_o=0.
